ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the execute-stage result: destination address, write enable, write data and HI/LO update.
- Honours the controller stall vector and flush.
- Holds the intermediate 64-bit accumulator and cycle count that execute needs for two-cycle multiply-accumulate (madd/msub) across a self-inserted stall.
- Maintains a saturating bubble counter for performance debug.

---
 rtl/ex_mem_reg_pkg.sv | 51 +++++
 rtl/ex_mem_reg_perf.sv | 30 +++
 rtl/ex_mem_reg.sv | 131 +++++++++++++
 tb/tb_ex_mem_reg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
// Holds the core-wide width/value constants, the stall-vector bit map and
// the per-edge operation decode shared by the stage register and its logic.
package ex_mem_reg_pkg;

  // Core-wide widths, named the way the rest of the pipeline refers to them.
  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;

  // Common values.
  localparam logic [RegBus-1:0] ZeroWord     = 32'h0000_0000;
  localparam logic              Stop         = 1'b1;
  localparam logic              NoStop       = 1'b0;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;

  // Controller stall vector layout: one bit per stage, pc at bit 0.
  localparam int STALL_W   = 6;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  // What the stage register does on a given clock edge.
  typedef enum logic [2:0] {
    OP_RESET  = 3'd0,
    OP_FLUSH  = 3'd1,
    OP_BUBBLE = 3'd2,
    OP_HOLD   = 3'd3,
    OP_PASS   = 3'd4
  } stage_op_e;

  // Priority: reset > flush > bubble > hold > pass.
  // Execute running while memory is stalled cannot come from a sane
  // controller; it falls through to pass so the pipeline keeps moving.
  function automatic stage_op_e decode_op(
    input logic               rst,
    input logic               flush,
    input logic [STALL_W-1:0] stall
  );
    stage_op_e op;
    if (rst)                                           op = OP_RESET;
    else if (flush)                                    op = OP_FLUSH;
    else if (stall[STALL_EX] == Stop &&
             stall[STALL_MEM] == NoStop)               op = OP_BUBBLE;
    else if (stall[STALL_EX] == Stop &&
             stall[STALL_MEM] == Stop)                 op = OP_HOLD;
    else                                               op = OP_PASS;
    return op;
  endfunction

endpackage

// File: rtl/ex_mem_reg_perf.sv
// Saturating bubble counter for performance debug.
// Latency: count visible the cycle after the increment request.
// Backpressure: none; sticks at all-ones instead of wrapping.
// Ports: clk, rst (sync, active-high), i_inc (count one bubble),
//        o_cnt (bubbles since reset).
module ex_mem_reg_perf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = (r_cnt == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the 5-stage MIPS core.
// Latency: one cycle from ex_* to mem_*; all outputs come straight from flops.
// Backpressure: stall[3]/stall[4] bubble or hold the stage; flush clears it.
// Ports:
//   clk, rst (sync, active-high), stall[5:0], flush
//   ex_*        execute result (valid, dest addr, wreg, wdata, whilo, hi, lo)
//   hilo_temp_i, cnt_i   madd/msub partial state from execute
//   mem_*       registered execute result for the memory stage
//   hilo_temp_o, cnt_o   partial state handed back to execute
//   bubble_cnt  saturating count of bubbles inserted since reset
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt
);

  stage_op_e w_op;

  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_wd;
  logic                r_mem_wreg;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_whilo;
  logic [DATA_W-1:0]   r_mem_hi;
  logic [DATA_W-1:0]   r_mem_lo;
  logic [2*DATA_W-1:0] r_hilo_temp;
  logic [CNT_W-1:0]    r_cnt;

  assign w_op = decode_op(rst, flush, stall);

  // Write enables are qualified by valid so a non-instruction can never
  // reach the register file or HI/LO, whatever execute left on the bus.
  always_ff @(posedge clk) begin
    case (w_op)
      OP_RESET, OP_FLUSH: begin
        r_mem_valid <= 1'b0;
        r_mem_wd    <= '0;
        r_mem_wreg  <= WriteDisable;
        r_mem_wdata <= '0;
        r_mem_whilo <= WriteDisable;
        r_mem_hi    <= '0;
        r_mem_lo    <= '0;
        r_hilo_temp <= '0;
        r_cnt       <= '0;
      end
      OP_BUBBLE: begin
        // Execute stalled itself mid madd/msub: send nothing downstream but
        // keep its partial product so the second cycle can finish it.
        r_mem_valid <= 1'b0;
        r_mem_wd    <= '0;
        r_mem_wreg  <= WriteDisable;
        r_mem_wdata <= '0;
        r_mem_whilo <= WriteDisable;
        r_mem_hi    <= '0;
        r_mem_lo    <= '0;
        r_hilo_temp <= hilo_temp_i;
        r_cnt       <= cnt_i;
      end
      OP_HOLD: begin
        r_mem_valid <= r_mem_valid;
        r_mem_wd    <= r_mem_wd;
        r_mem_wreg  <= r_mem_wreg;
        r_mem_wdata <= r_mem_wdata;
        r_mem_whilo <= r_mem_whilo;
        r_mem_hi    <= r_mem_hi;
        r_mem_lo    <= r_mem_lo;
        r_hilo_temp <= r_hilo_temp;
        r_cnt       <= r_cnt;
      end
      default: begin
        r_mem_valid <= ex_valid;
        r_mem_wd    <= ex_wd;
        r_mem_wreg  <= ex_wreg & ex_valid;
        r_mem_wdata <= ex_wdata;
        r_mem_whilo <= ex_whilo & ex_valid;
        r_mem_hi    <= ex_hi;
        r_mem_lo    <= ex_lo;
        r_hilo_temp <= '0;
        r_cnt       <= '0;
      end
    endcase
  end

  // Flushes are not bubbles; only the execute-only stall is counted.
  ex_mem_reg_perf #(
    .W (PERF_W)
  ) u_perf (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_op == OP_BUBBLE),
    .o_cnt (bubble_cnt)
  );

  assign mem_valid   = r_mem_valid;
  assign mem_wd      = r_mem_wd;
  assign mem_wreg    = r_mem_wreg;
  assign mem_wdata   = r_mem_wdata;
  assign mem_whilo   = r_mem_whilo;
  assign mem_hi      = r_mem_hi;
  assign mem_lo      = r_mem_lo;
  assign hilo_temp_o = r_hilo_temp;
  assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;

  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  logic [15:0] bubble_cnt;

  // Narrow-counter instance, sharing the stimulus, for saturation.
  logic        mem_valid4;
  logic [4:0]  mem_wd4;
  logic        mem_wreg4;
  logic [31:0] mem_wdata4;
  logic        mem_whilo4;
  logic [31:0] mem_hi4;
  logic [31:0] mem_lo4;
  logic [63:0] hilo_temp_o4;
  logic [1:0]  cnt_o4;
  logic [3:0]  bubble_cnt4;

  int n_tests = 0;
  int n_fail  = 0;
  int bc      = 0;   // expected bubble count since last reset

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt)
  );

  ex_mem_reg #(.PERF_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid4), .mem_wd(mem_wd4), .mem_wreg(mem_wreg4),
    .mem_wdata(mem_wdata4), .mem_whilo(mem_whilo4), .mem_hi(mem_hi4),
    .mem_lo(mem_lo4), .hilo_temp_o(hilo_temp_o4), .cnt_o(cnt_o4),
    .bubble_cnt(bubble_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The controller must never run execute while memory is stalled.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(!stall[3] && stall[4]))
        else $error("illegal stall vector %b from controller", stall);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_bubbles(input string tag);
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bc));
    chk({tag, ".bubble_cnt4"}, 64'(bubble_cnt4), 64'((bc > 15) ? 15 : bc));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, ".mem_wd"},    64'(mem_wd),    64'd0);
    chk({tag, ".mem_wreg"},  64'(mem_wreg),  64'd0);
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, ".mem_whilo"}, 64'(mem_whilo), 64'd0);
    chk({tag, ".mem_hi"},    64'(mem_hi),    64'd0);
    chk({tag, ".mem_lo"},    64'(mem_lo),    64'd0);
  endtask

  initial begin
    // Reset for two cycles with random inputs.
    rst         = 1'b1;
    flush       = 1'b0;
    stall       = 6'b001111;
    ex_valid    = 1'b1;
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'b1;
    ex_wdata    = $urandom;
    ex_whilo    = 1'b1;
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    hilo_temp_i = {$urandom, $urandom};
    cnt_i       = 2'b11;
    tick();
    ex_wdata = $urandom;
    tick();
    chk_cleared("reset");
    chk("reset.hilo_temp_o", hilo_temp_o, 64'd0);
    chk("reset.cnt_o", 64'(cnt_o), 64'd0);
    chk_bubbles("reset");

    // Pass.
    rst         = 1'b0;
    stall       = 6'b000000;
    ex_valid    = 1'b1;
    ex_wd       = 5'd3;
    ex_wreg     = 1'b1;
    ex_wdata    = 32'hDEADBEEF;
    ex_whilo    = 1'b1;
    ex_hi       = 32'hAAAA_0001;
    ex_lo       = 32'h5555_0002;
    hilo_temp_i = 64'hFFFF_0000_1111_2222;
    cnt_i       = 2'b10;
    tick();
    chk("pass.mem_valid", 64'(mem_valid), 64'd1);
    chk("pass.mem_wd", 64'(mem_wd), 64'd3);
    chk("pass.mem_wreg", 64'(mem_wreg), 64'd1);
    chk("pass.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("pass.mem_whilo", 64'(mem_whilo), 64'd1);
    chk("pass.mem_hi", 64'(mem_hi), 64'hAAAA_0001);
    chk("pass.mem_lo", 64'(mem_lo), 64'h5555_0002);
    chk("pass.hilo_temp_o", hilo_temp_o, 64'd0);
    chk("pass.cnt_o", 64'(cnt_o), 64'd0);
    chk_bubbles("pass");

    // madd bubble: partial product carried back to execute.
    stall       = 6'b001111;
    hilo_temp_i = 64'h1_0000_0002;
    cnt_i       = 2'b01;
    tick();
    bc++;
    chk_cleared("bubble");
    chk("bubble.hilo_temp_o", hilo_temp_o, 64'h1_0000_0002);
    chk("bubble.cnt_o", 64'(cnt_o), 64'd1);
    chk_bubbles("bubble");

    // Next cycle the finished result passes; partial state clears.
    stall       = 6'b000000;
    ex_wd       = 5'd7;
    ex_wreg     = 1'b0;
    ex_whilo    = 1'b1;
    ex_wdata    = 32'h0BAD_F00D;
    ex_hi       = 32'h0000_0001;
    ex_lo       = 32'h0000_0004;
    cnt_i       = 2'b10;
    tick();
    chk("madd_done.mem_valid", 64'(mem_valid), 64'd1);
    chk("madd_done.mem_wd", 64'(mem_wd), 64'd7);
    chk("madd_done.mem_wreg", 64'(mem_wreg), 64'd0);
    chk("madd_done.mem_whilo", 64'(mem_whilo), 64'd1);
    chk("madd_done.mem_lo", 64'(mem_lo), 64'h4);
    chk("madd_done.hilo_temp_o", hilo_temp_o, 64'd0);
    chk("madd_done.cnt_o", 64'(cnt_o), 64'd0);
    chk_bubbles("madd_done");

    // Hold: load a value then stall both stages with changing inputs.
    ex_wdata = 32'h12345678;
    ex_wd    = 5'd9;
    ex_wreg  = 1'b1;
    tick();
    chk("hold_load.mem_wdata", 64'(mem_wdata), 64'h12345678);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata    = 32'hCAFE_0000 + 32'(i);
      ex_wd       = 5'(20 + i);
      hilo_temp_i = 64'(i + 100);
      cnt_i       = 2'(i);
      tick();
      chk("hold.mem_wdata", 64'(mem_wdata), 64'h12345678);
      chk("hold.mem_wd", 64'(mem_wd), 64'd9);
      chk("hold.mem_valid", 64'(mem_valid), 64'd1);
      chk("hold.cnt_o", 64'(cnt_o), 64'd0);
      chk_bubbles("hold");
    end

    // Hold after a bubble keeps the partial product, not the new input.
    stall       = 6'b001111;
    hilo_temp_i = 64'h0000_00AB_0000_00CD;
    cnt_i       = 2'b01;
    tick();
    bc++;
    stall       = 6'b011111;
    hilo_temp_i = 64'h1234;
    cnt_i       = 2'b11;
    tick();
    chk("hold_bub.hilo_temp_o", hilo_temp_o, 64'h0000_00AB_0000_00CD);
    chk("hold_bub.cnt_o", 64'(cnt_o), 64'd1);
    chk("hold_bub.mem_wreg", 64'(mem_wreg), 64'd0);
    chk_bubbles("hold_bub");

    // Flush beats bubble and is not counted.
    flush       = 1'b1;
    stall       = 6'b001111;
    hilo_temp_i = 64'h77;
    cnt_i       = 2'b11;
    tick();
    chk_cleared("flush");
    chk("flush.hilo_temp_o", hilo_temp_o, 64'd0);
    chk("flush.cnt_o", 64'(cnt_o), 64'd0);
    chk_bubbles("flush");

    // Reset beats flush.
    flush = 1'b0;
    stall = 6'b000000;
    tick();   // load a live instruction first
    chk("pre_rst.mem_valid", 64'(mem_valid), 64'd1);
    rst   = 1'b1;
    flush = 1'b1;
    stall = 6'b001111;
    tick();
    bc = 0;
    chk_cleared("rst_flush");
    chk("rst_flush.cnt_o", 64'(cnt_o), 64'd0);
    chk_bubbles("rst_flush");

    // Saturation: 20 consecutive bubbles, then more.
    rst   = 1'b0;
    flush = 1'b0;
    stall = 6'b001111;
    for (int i = 0; i < 23; i++) begin
      cnt_i = 2'(i);
      tick();
      bc++;
      chk_bubbles("sat");
    end
    chk("sat.final4", 64'(bubble_cnt4), 64'hF);
    stall = 6'b011111;
    tick();
    chk_bubbles("sat_hold");
    stall = 6'b000000;
    tick();
    chk_bubbles("sat_pass");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
